fmap_rd_seq: RTL

//  Read-side sequencer for the dffram feature-map buffer. On start it walks LEN consecutive

---
 rtl/fmap_rd_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fmap_rd_seq.sv
// Read-side sequencer for the feature-map buffer.
// Walks a burst of RAM reads and streams the words out through a 4-deep FIFO.
module fmap_rd_seq #(
  parameter int DWIDTH = 24,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] base,
  input  logic [AWIDTH:0]   len,
  output logic [AWIDTH-1:0] ram_adr_r,
  input  logic [DWIDTH-1:0] ram_dat,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [AWIDTH:0] ONE = 1;

  state_t state;

  // reads still to be issued in this burst
  logic [AWIDTH:0] remain;

  // p1: read issued last edge, RAM registers it now
  // p2: RAM output valid now, pushed at this edge
  logic p1, p2;
  logic l1, l2;

  logic [DWIDTH-1:0] fmem [4];
  logic [3:0]        flast;
  logic [1:0]        wptr;
  logic [1:0]        rptr;
  logic [2:0]        cnt;

  logic [2:0] inflight;
  logic       issue;
  logic       push;
  logic       pop;

  // credit check uses occupancy before this edge; pops are not credited
  always_comb begin
    inflight = {2'b0, p1} + {2'b0, p2};
    issue    = (state == RUN) && ((cnt + inflight) < 3'd4);
    push     = p2;
    pop      = m_valid & m_ready;
  end

  // show-ahead head of the FIFO drives the stream
  always_comb begin
    m_valid = (cnt != 3'd0);
    m_data  = fmem[rptr];
    m_last  = flast[rptr] & m_valid;
  end

  // burst FSM, address counter and read pipeline tags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remain    <= '0;
      ram_adr_r <= '0;
      p1        <= 1'b0;
      p2        <= 1'b0;
      l1        <= 1'b0;
      l2        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      p2   <= p1;
      l2   <= l1;
      p1   <= 1'b0;
      l1   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              busy      <= 1'b1;
              ram_adr_r <= base;
              p1        <= 1'b1;
              l1        <= (len == ONE);
              remain    <= len - ONE;
              state     <= (len == ONE) ? DRAIN : RUN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            ram_adr_r <= ram_adr_r + 1'b1;
            p1        <= 1'b1;
            l1        <= (remain == ONE);
            remain    <= remain - ONE;
            if (remain == ONE) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // output FIFO, depth 4; push and pop together keep the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        fmem[i] <= '0;
      end
      flast <= '0;
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
    end else begin
      if (push) begin
        fmem[wptr]  <= ram_dat;
        flast[wptr] <= l2;
        wptr        <= wptr + 2'd1;
      end
      if (pop) begin
        rptr <= rptr + 2'd1;
      end
      cnt <= cnt + {2'b0, push} - {2'b0, pop};
    end
  end

endmodule
